// File: rtl/alu_muldiv_controller.sv
// Execute-stage ALU operation decoder plus an iterative radix-2 sequencer
// for the RV32M multiply/divide group, with a stall toward the pipeline.
module alu_muldiv_controller #(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      ALUOp,
    input  logic [6:0]      Funct7,
    input  logic [2:0]      Funct3,
    input  logic            IsRType,
    input  logic            InValid,
    input  logic            Flush,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    output logic [3:0]      Operation,
    output logic            MulDivSel,
    output logic            Stall,
    output logic            MulDivDone,
    output logic [XLEN-1:0] MulDivResult
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST_STEP = CW'(XLEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [2:0]        r_f3;
    logic [XLEN-1:0]   r_m;
    logic [2*XLEN-1:0] r_acc;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_done;
    logic [XLEN-1:0]   r_result;

    always_comb begin
        Operation = 4'b0000;
        case (ALUOp)
            2'b00: Operation = 4'b0011;
            2'b01: begin
                case (Funct3)
                    3'b000:  Operation = 4'b1000;
                    3'b001:  Operation = 4'b0100;
                    3'b100:  Operation = 4'b0101;
                    3'b101:  Operation = 4'b0110;
                    3'b110:  Operation = 4'b1110;
                    3'b111:  Operation = 4'b1111;
                    default: Operation = 4'b0000;
                endcase
            end
            2'b10: begin
                case (Funct3)
                    3'b000:  Operation = (IsRType && Funct7 == 7'b0100000) ? 4'b1001 : 4'b0011;
                    3'b001:  Operation = 4'b1100;
                    3'b010:  Operation = 4'b0111;
                    3'b011:  Operation = 4'b1110;
                    3'b100:  Operation = 4'b0010;
                    3'b101:  Operation = Funct7[5] ? 4'b1010 : 4'b1011;
                    3'b110:  Operation = 4'b0001;
                    default: Operation = 4'b0000;
                endcase
            end
            default: Operation = (Funct3 == 3'b000) ? 4'b1101 : 4'b0000;
        endcase
    end

    logic w_is_m;
    assign w_is_m    = ENABLE_M && (ALUOp == 2'b10) && IsRType && (Funct7 == 7'b0000001);
    assign MulDivSel = w_is_m;
    // Stall is dropped during reset and flush so the pipeline is never held by a dead op.
    assign Stall     = rst_n & InValid & w_is_m & ~Flush & (r_state != S_DONE);

    logic            w_is_div, w_a_signed, w_b_signed, w_a_neg, w_b_neg;
    logic [XLEN-1:0] w_a_mag, w_b_mag;
    logic            w_div0, w_ovf;
    logic [XLEN-1:0] w_special;

    assign w_is_div   = Funct3[2];
    assign w_a_signed = w_is_div ? ~Funct3[0] : ~(Funct3[1] & Funct3[0]);
    assign w_b_signed = w_is_div ? ~Funct3[0] : ~Funct3[1];
    assign w_a_neg    = w_a_signed & SrcA[XLEN-1];
    assign w_b_neg    = w_b_signed & SrcB[XLEN-1];
    assign w_a_mag    = w_a_neg ? -SrcA : SrcA;
    assign w_b_mag    = w_b_neg ? -SrcB : SrcB;
    assign w_div0     = w_is_div && (SrcB == '0);
    assign w_ovf      = w_is_div && !Funct3[0] && (SrcA == {1'b1, {(XLEN-1){1'b0}}}) && (SrcB == '1);
    assign w_special  = w_div0 ? (Funct3[1] ? SrcA : '1) : (Funct3[1] ? '0 : SrcA);

    // r_acc is {high, low}: accumulator/multiplier for mul, remainder/quotient for div.
    logic [XLEN:0]     w_mul_sum, w_div_shift, w_div_diff;
    logic [2*XLEN-1:0] w_mul_next, w_div_next, w_next, w_prod;
    logic [XLEN-1:0]   w_quot, w_rem, w_final;

    assign w_mul_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_m} : '0);
    assign w_mul_next  = {w_mul_sum, r_acc[XLEN-1:1]};
    assign w_div_shift = r_acc[2*XLEN-1:XLEN-1];
    assign w_div_diff  = w_div_shift - {1'b0, r_m};
    assign w_div_next  = w_div_diff[XLEN] ? {w_div_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                          : {w_div_diff[XLEN-1:0],  r_acc[XLEN-2:0], 1'b1};
    assign w_next      = r_f3[2] ? w_div_next : w_mul_next;
    assign w_prod      = r_neg_q ? -w_next : w_next;
    assign w_quot      = r_neg_q ? -w_next[XLEN-1:0] : w_next[XLEN-1:0];
    assign w_rem       = r_neg_r ? -w_next[2*XLEN-1:XLEN] : w_next[2*XLEN-1:XLEN];

    always_comb begin
        w_final = '0;
        case (r_f3)
            3'b000:         w_final = w_prod[XLEN-1:0];
            3'b100, 3'b101: w_final = w_quot;
            3'b110, 3'b111: w_final = w_rem;
            default:        w_final = w_prod[2*XLEN-1:XLEN];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_f3     <= '0;
            r_m      <= '0;
            r_acc    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            if (Flush) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (InValid && w_is_m) begin
                            r_f3    <= Funct3;
                            r_m     <= w_b_mag;
                            r_acc   <= {{XLEN{1'b0}}, w_a_mag};
                            r_neg_q <= w_a_neg ^ w_b_neg;
                            r_neg_r <= w_a_neg;
                            r_cnt   <= '0;
                            if (w_div0 || w_ovf) begin
                                r_result <= w_special;
                                r_done   <= 1'b1;
                                r_state  <= S_DONE;
                            end else begin
                                r_state <= S_CALC;
                            end
                        end
                    end
                    S_CALC: begin
                        r_acc <= w_next;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LAST_STEP) begin
                            r_result <= w_final;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign MulDivDone   = r_done;
    assign MulDivResult = r_result;
endmodule

// File: tb/tb_alu_muldiv_controller.sv
// Bench for alu_muldiv_controller: decode sweep, directed and random mul/div
// against an arithmetic reference, flush and reset-abort scenarios.
module tb_alu_muldiv_controller;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  ALUOp;
    logic [6:0]  Funct7;
    logic [2:0]  Funct3;
    logic        IsRType, InValid, Flush;
    logic [31:0] SrcA, SrcB;
    logic [3:0]  Operation;
    logic        MulDivSel, Stall, MulDivDone;
    logic [31:0] MulDivResult;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_res = '0;

    localparam logic [3:0] BR_TBL  [8] = '{4'h8, 4'h4, 4'h0, 4'h0, 4'h5, 4'h6, 4'he, 4'hf};
    localparam logic [3:0] ALU_TBL [8] = '{4'h3, 4'hc, 4'h7, 4'he, 4'h2, 4'hb, 4'h1, 4'h0};

    alu_muldiv_controller #(.XLEN(32), .ENABLE_M(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3),
        .IsRType(IsRType), .InValid(InValid), .Flush(Flush), .SrcA(SrcA), .SrcB(SrcB),
        .Operation(Operation), .MulDivSel(MulDivSel), .Stall(Stall),
        .MulDivDone(MulDivDone), .MulDivResult(MulDivResult)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] ref_op(input logic [1:0] aluop, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic isr);
        logic [3:0] r;
        case (aluop)
            2'd0: r = 4'h3;
            2'd1: r = BR_TBL[f3];
            2'd2: begin
                r = ALU_TBL[f3];
                if (f3 == 3'd0 && isr && f7 == 7'h20) r = 4'h9;
                if (f3 == 3'd5 && f7[5]) r = 4'ha;
            end
            default: r = (f3 == 3'd0) ? 4'hd : 4'h0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        int ia, ib;
        logic ovf;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        ia = int'(a);
        ib = int'(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hffff_ffff);
        p = 0;
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hffff_ffff : ovf ? a : 32'(ia / ib);
            3'd5: return (b == 0) ? 32'hffff_ffff : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(ia % ib);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        return f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hffff_ffff));
    endfunction

    task automatic drive_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        ALUOp = 2'b10; IsRType = 1'b1; Funct7 = 7'h01; Funct3 = f3;
        SrcA = a; SrcB = b; InValid = 1'b1; Flush = 1'b0;
    endtask

    // Issue one M op right after a clock edge and follow it to its done pulse.
    task automatic run_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int lat, done_at, stalls;
        logic [31:0] exp;
        exp = ref_md(f3, a, b);
        lat = is_special(f3, a, b) ? 1 : 33;
        @(posedge clk); #1;
        drive_m(f3, a, b);
        @(negedge clk);
        check("sel", MulDivSel, 1);
        check("hold", MulDivResult, last_res);
        done_at = -1;
        stalls  = 0;
        for (int c = 0; c < 40 && done_at < 0; c++) begin
            if (c > 0) @(negedge clk);
            if (Stall) stalls++;
            if (MulDivDone) done_at = c;
        end
        check("done_cycle", 64'(done_at), 64'(lat));
        check("stall_cycles", 64'(stalls), 64'(lat));
        check("result", MulDivResult, exp);
        last_res = exp;
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (MulDivDone) n++;
        end
    endtask

    initial begin
        int n_done;
        logic [6:0] f7s [4];
        logic [2:0] f3;
        logic [31:0] a, b;
        logic exp_sel;

        rst_n = 1'b0; ALUOp = '0; Funct7 = '0; Funct3 = '0; IsRType = 1'b0;
        InValid = 1'b0; Flush = 1'b0; SrcA = '0; SrcB = '0;
        #12;
        check("rst_done", MulDivDone, 0);
        check("rst_result", MulDivResult, 0);
        check("rst_stall", Stall, 0);
        @(negedge clk); rst_n = 1'b1;

        f7s = '{7'h00, 7'h20, 7'h01, 7'($urandom)};
        for (int al = 0; al < 4; al++)
            for (int f = 0; f < 8; f++)
                for (int r = 0; r < 2; r++)
                    for (int k = 0; k < 4; k++) begin
                        exp_sel = (al == 2) && (r == 1) && (f7s[k] == 7'h01);
                        ALUOp = 2'(al); Funct3 = 3'(f); IsRType = r[0]; Funct7 = f7s[k];
                        InValid = ~exp_sel;
                        #1;
                        check("op", Operation, ref_op(2'(al), 3'(f), f7s[k], r[0]));
                        check("sel_sweep", MulDivSel, exp_sel);
                        check("nonm_stall", Stall, 0);
                    end
        ALUOp = 2'b10; Funct3 = 3'd0; IsRType = 1'b0; Funct7 = 7'h20; #1;
        check("itype_add", Operation, 4'h3);
        IsRType = 1'b1; #1;
        check("rtype_sub", Operation, 4'h9);
        IsRType = 1'b0; Funct3 = 3'd5; #1;
        check("srai", Operation, 4'ha);
        InValid = 1'b0;

        run_md(3'd0, 32'd7, 32'hffff_fffd);
        run_md(3'd3, 32'hffff_ffff, 32'hffff_ffff);
        run_md(3'd1, 32'hffff_ffff, 32'hffff_ffff);
        run_md(3'd5, 32'd100, 32'd0);
        run_md(3'd6, 32'd5, 32'd0);
        run_md(3'd4, 32'h8000_0000, 32'hffff_ffff);
        run_md(3'd6, 32'hffff_fff9, 32'd2);
        run_md(3'd4, 32'hffff_fff9, 32'd2);
        run_md(3'd5, 32'd1000, 32'd7);

        for (int i = 0; i < 30; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: begin a = 32'h8000_0000; b = 32'hffff_ffff; end
                2: begin a = $urandom_range(0, 50); b = $urandom_range(1, 9); end
                3: b = 32'($urandom_range(0, 16)) - 32'd8;
                default: ;
            endcase
            run_md(f3, a, b);
        end

        // Flush in the tenth calc cycle aborts without a done pulse.
        @(posedge clk); #1;
        drive_m(3'd0, 32'h1234, 32'h5678);
        for (int c = 1; c <= 10; c++) @(posedge clk);
        #1; Flush = 1'b1; #1;
        check("flush_stall", Stall, 0);
        @(posedge clk); #1; Flush = 1'b0; InValid = 1'b0;
        count_done(40, n_done);
        check("flush_no_done", 64'(n_done), 0);
        check("flush_hold", MulDivResult, last_res);
        run_md(3'd7, 32'd100, 32'd7);

        // Asynchronous reset in the middle of a divide.
        @(posedge clk); #1;
        drive_m(3'd4, 32'd1000, 32'd3);
        for (int c = 0; c < 5; c++) @(posedge clk);
        #1; rst_n = 1'b0; #1;
        check("midrst_stall", Stall, 0);
        check("midrst_done", MulDivDone, 0);
        check("midrst_result", MulDivResult, 0);
        @(posedge clk); #1; InValid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        count_done(40, n_done);
        check("rst_no_done", 64'(n_done), 0);
        last_res = '0;
        run_md(3'd0, 32'd3, 32'd4);

        @(posedge clk); #1; InValid = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_muldiv_controller.md
Name: alu_muldiv_controller

Overview:
- Parametrised successor to the combinational ALU operation decoder.
- Decodes ALUOp/Funct3/Funct7 into the 4-bit ALU Operation code (base RV32I set plus SLTU).
- Adds an iterative sequencer for the RV32M multiply/divide group, with a stall handshake toward the pipeline.
- Sits in the execute stage beside the ALU. Its result mux select chooses between ALU and mul/div results.

Parameters:
- XLEN, 32, operand/result width (power of two, ≥8).
- ENABLE_M, 1, 0 = M-extension decode disabled; M encodings decode as base R-type ops and the sequencer is never entered.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- ALUOp  in  2  00 LW/SW/AUIPC, 01 branch, 10 R/I-type, 11 U-type/JALR
- Funct7  in  7  instr[31:25]
- Funct3  in  3  instr[14:12]
- IsRType  in  1  1 = R-type (Funct7 meaningful), 0 = I-type
- InValid  in  1  execute-stage instruction valid
- Flush  in  1  synchronous abort of the in-flight mul/div
- SrcA  in  XLEN  rs1 operand
- SrcB  in  XLEN  rs2 operand
- Operation  out  4  ALU operation code
- MulDivSel  out  1  1 = execute result comes from MulDivResult
- Stall  out  1  hold pipeline (fetch/decode/execute)
- MulDivDone  out  1  one-cycle pulse, result valid
- MulDivResult  out  XLEN  mul/div result

Behaviour:
- Operation decode (combinational):
  - ALUOp=00: 0011 (add)
  - ALUOp=01 (branches):
    - Funct3 000 beq: 1000
    - Funct3 001 bne: 0100
    - Funct3 100 blt: 0101
    - Funct3 101 bge: 0110
    - Funct3 110 bltu: 1110
    - Funct3 111 bgeu: 1111
  - ALUOp=10, by Funct3:
    - 000: add 0011; sub 1001 (only when IsRType=1 and Funct7=0100000). I-type 000 is always add.
    - 001: sll 1100
    - 010: slt 0111
    - 011: sltu 1110
    - 100: xor 0010
    - 101: srl 1011; sra 1010 (when Funct7[5]=1, both R and I)
    - 110: or 0001
    - 111: and 0000
  - ALUOp=11 with Funct3=000: 1101 (jalr).
  - Any undecoded combination: 0000.
- IsM = ENABLE_M & (ALUOp=10) & IsRType & (Funct7=0000001). Funct3 selects the op:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- MulDivSel = IsM (combinational).
- FSM states: IDLE, CALC, DONE. Reset state is IDLE.
- Reset values (async, rst_n low): state IDLE, counter 0, all internal registers 0, MulDivDone 0, MulDivResult 0.
- IDLE:
  - InValid & IsM & ~Flush: latch SrcA/SrcB/Funct3.
  - For signed operands, convert to magnitudes and record the result sign.
  - Set counter to 0 and go to CALC.
  - Special divide cases skip CALC and go directly to DONE:
    - Divide by zero: quotient = all-ones; remainder = dividend.
    - Signed overflow (DIV/REM with SrcA = −2^(XLEN−1), SrcB = −1): quotient = SrcA; remainder = 0.
- CALC:
  - One radix-2 step per cycle: shift-add multiply (2·XLEN product) or restoring divide.
  - Counter increments each cycle; after XLEN steps, go to DONE.
  - Signed results are negated at the transition into DONE.
- DONE:
  - MulDivResult is registered.
  - MULH* selects the high half of the product, MUL the low half; DIV/DIVU the quotient, REM/REMU the remainder.
  - Remainder sign follows the dividend.
  - MulDivDone = 1 for exactly this cycle, then the FSM returns to IDLE.
- Stall = InValid & IsM & (state ≠ DONE). The issuing instruction therefore stays in execute until DONE.
- Latency:
  - Normal op: issue cycle (IDLE) + XLEN CALC cycles, DONE at cycle XLEN+1; Stall is high for XLEN+1 cycles.
  - Special case: Stall is high for 1 cycle.
- Back-to-back M ops: DONE→IDLE, and the next M op issues in that IDLE cycle. There is no zero-cycle reuse of DONE.
- MulDivResult holds its value until the next DONE.
- Flush high in any state: go to IDLE next cycle, no MulDivDone, Stall low in the cycle Flush is asserted.
- Reset mid-operation: immediate IDLE; no Done pulse after release.
- Non-M instructions never touch the FSM. Stall stays 0 for them.

Test Plan:
- Decode sweep: all ALUOp/Funct3/Funct7/IsRType combos → codes as listed. Spot checks:
  - I-type Funct3=000 with Funct7=0100000 → 0011
  - R-type sub → 1001
  - srai → 1010
- MUL SrcA=7, SrcB=0xFFFFFFFD, issued at cycle 0 → Stall 1 for cycles 0..32; MulDivDone at cycle 33; result 0xFFFFFFEB.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH same operands → 0x00000000.
- DIVU 100/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. Each with MulDivDone at cycle 1.
- REM 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFF; DIV same → 0xFFFFFFFD. A DIVU issued in the following cycle completes correctly (back-to-back).
- Flush at CALC cycle 10 → no MulDivDone, FSM IDLE. rst_n low mid-CALC → all outputs 0 immediately. A subsequent MUL 3×4 → 12.
